// File: rtl/spi_receiver.sv
// spi_receiver: SPI receive-side deserializer.
// Synchronizes SCK/CS/MISO into clk_100, samples MISO on the mode-selected
// SCK edge while CS is low, and hands completed words to the fabric through
// a single valid/ready holding register with overrun and framing reporting.
`timescale 1ns/1ps

module spi_receiver #(
  parameter int P_DATA_WIDTH = 8,
  parameter int P_CPOL       = 0,
  parameter int P_CPHA       = 0,
  parameter int P_MSB_FIRST  = 1
) (
  input  logic                    clk_100,
  input  logic                    a_rst_n,
  input  logic                    SCK,
  input  logic                    CS,
  input  logic                    MISO,
  output logic [P_DATA_WIDTH-1:0] data_out,
  output logic                    valid,
  input  logic                    ready,
  output logic                    overrun,
  input  logic                    ovr_clr,
  output logic                    frame_err,
  output logic                    busy
);

  localparam int CNT_W = (P_DATA_WIDTH > 1) ? $clog2(P_DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(P_DATA_WIDTH - 1);
  localparam logic SCK_IDLE = (P_CPOL != 0);
  // Modes 0 and 3 sample on the rising SCK edge, modes 1 and 2 on the falling.
  localparam bit SAMPLE_RISE = ((P_CPOL != 0) == (P_CPHA != 0));

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } state_t;

  // Synchronizer and edge-detect history
  logic sck_s1_reg, sck_s2_reg, sck_s3_reg;
  logic cs_s1_reg, cs_s2_reg, cs_s3_reg;
  logic miso_s1_reg, miso_s2_reg;

  // Post-reset CS arming
  logic [1:0] warm_cnt_reg;
  logic       armed_reg;

  // FSM and datapath
  state_t                  state_reg, state_next;
  logic [CNT_W-1:0]        bit_cnt_reg, bit_cnt_next;
  logic [P_DATA_WIDTH-1:0] shift_reg, shift_next;
  logic [P_DATA_WIDTH-1:0] shift_in;
  logic [P_DATA_WIDTH-1:0] data_reg, data_next;
  logic                    valid_reg, valid_next;
  logic                    overrun_reg, overrun_next;
  logic                    frame_err_next, frame_err_reg;
  logic                    busy_reg;
  logic                    word_done;

  logic sck_rise, sck_fall, sample_edge, cs_fall, cs_rise;

  // Two-flop synchronizers plus a third stage of SCK/CS history for edge detection
  always_ff @(posedge clk_100 or negedge a_rst_n) begin
    if (!a_rst_n) begin
      sck_s1_reg  <= SCK_IDLE;
      sck_s2_reg  <= SCK_IDLE;
      sck_s3_reg  <= SCK_IDLE;
      cs_s1_reg   <= 1'b1;
      cs_s2_reg   <= 1'b1;
      cs_s3_reg   <= 1'b1;
      miso_s1_reg <= 1'b0;
      miso_s2_reg <= 1'b0;
    end else begin
      sck_s1_reg  <= SCK;
      sck_s2_reg  <= sck_s1_reg;
      sck_s3_reg  <= sck_s2_reg;
      cs_s1_reg   <= CS;
      cs_s2_reg   <= cs_s1_reg;
      cs_s3_reg   <= cs_s2_reg;
      miso_s1_reg <= MISO;
      miso_s2_reg <= miso_s1_reg;
    end
  end

  // A CS falling edge only counts once the synchronizer holds a genuinely
  // sampled high CS; this keeps a CS held low across reset from looking like
  // a fresh frame start when the reset-preset flops flush out.
  always_ff @(posedge clk_100 or negedge a_rst_n) begin
    if (!a_rst_n) begin
      warm_cnt_reg <= 2'd0;
      armed_reg    <= 1'b0;
    end else begin
      if (warm_cnt_reg != 2'd2) begin
        warm_cnt_reg <= warm_cnt_reg + 2'd1;
      end
      if ((warm_cnt_reg == 2'd2) && cs_s2_reg) begin
        armed_reg <= 1'b1;
      end
    end
  end

  assign sck_rise    = sck_s2_reg & ~sck_s3_reg;
  assign sck_fall    = ~sck_s2_reg & sck_s3_reg;
  assign sample_edge = SAMPLE_RISE ? sck_rise : sck_fall;
  assign cs_fall     = armed_reg & ~cs_s2_reg & cs_s3_reg;
  assign cs_rise     = cs_s2_reg & ~cs_s3_reg;

  // Shift register value after taking in the current MISO bit
  generate
    if (P_MSB_FIRST != 0) begin : g_msb_first
      assign shift_in = {shift_reg[P_DATA_WIDTH-2:0], miso_s2_reg};
    end else begin : g_lsb_first
      assign shift_in = {miso_s2_reg, shift_reg[P_DATA_WIDTH-1:1]};
    end
  endgenerate

  // Next-state, bit counting, framing check and holding-register decisions
  always_comb begin
    state_next     = state_reg;
    bit_cnt_next   = bit_cnt_reg;
    shift_next     = shift_reg;
    word_done      = 1'b0;
    frame_err_next = 1'b0;
    data_next      = data_reg;
    valid_next     = valid_reg;
    overrun_next   = overrun_reg;

    case (state_reg)
      IDLE: begin
        if (cs_fall) begin
          state_next   = RECV;
          bit_cnt_next = '0;
          shift_next   = '0;
        end
      end
      RECV: begin
        if (cs_rise) begin
          // End of frame wins over a coincident sample edge; a partial word is dropped.
          state_next     = IDLE;
          frame_err_next = (bit_cnt_reg != '0);
          bit_cnt_next   = '0;
          shift_next     = '0;
        end else if (sample_edge) begin
          shift_next = shift_in;
          if (bit_cnt_reg == LAST_BIT) begin
            word_done    = 1'b1;
            bit_cnt_next = '0;
          end else begin
            bit_cnt_next = bit_cnt_reg + 1'b1;
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    if (valid_reg && ready) begin
      valid_next = 1'b0;
    end
    if (ovr_clr) begin
      overrun_next = 1'b0;
    end
    if (word_done) begin
      if (!valid_reg || ready) begin
        data_next  = shift_in;
        valid_next = 1'b1;
      end else begin
        overrun_next = 1'b1;
      end
    end
  end

  // State, datapath and registered outputs
  always_ff @(posedge clk_100 or negedge a_rst_n) begin
    if (!a_rst_n) begin
      state_reg     <= IDLE;
      bit_cnt_reg   <= '0;
      shift_reg     <= '0;
      data_reg      <= '0;
      valid_reg     <= 1'b0;
      overrun_reg   <= 1'b0;
      frame_err_reg <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      bit_cnt_reg   <= bit_cnt_next;
      shift_reg     <= shift_next;
      data_reg      <= data_next;
      valid_reg     <= valid_next;
      overrun_reg   <= overrun_next;
      frame_err_reg <= frame_err_next;
      busy_reg      <= (state_next == RECV);
    end
  end

  assign data_out  = data_reg;
  assign valid     = valid_reg;
  assign overrun   = overrun_reg;
  assign frame_err = frame_err_reg;
  assign busy      = busy_reg;

endmodule

// File: tb/tb_spi_receiver.sv
// tb_spi_receiver: scoreboard bench for spi_receiver.
// dut0 runs mode 0 MSB-first, dut1 runs mode 3 LSB-first. Expected words are
// queued as frames are driven and popped on every valid/ready handshake.
`timescale 1ns/1ps

module tb_spi_receiver;

  localparam int W = 8;
  localparam int H = 5;  // SCK half-period in clk_100 cycles

  logic clk_100 = 1'b0;
  always #5 clk_100 = ~clk_100;

  logic a_rst_n;

  logic         sck0, cs0, miso0, ready0, ovr_clr0;
  logic [W-1:0] data_out0;
  logic         valid0, overrun0, frame_err0, busy0;

  logic         sck1, cs1, miso1, ready1, ovr_clr1;
  logic [W-1:0] data_out1;
  logic         valid1, overrun1, frame_err1, busy1;

  spi_receiver #(.P_DATA_WIDTH(W), .P_CPOL(0), .P_CPHA(0), .P_MSB_FIRST(1)) dut0 (
    .clk_100  (clk_100),
    .a_rst_n  (a_rst_n),
    .SCK      (sck0),
    .CS       (cs0),
    .MISO     (miso0),
    .data_out (data_out0),
    .valid    (valid0),
    .ready    (ready0),
    .overrun  (overrun0),
    .ovr_clr  (ovr_clr0),
    .frame_err(frame_err0),
    .busy     (busy0)
  );

  spi_receiver #(.P_DATA_WIDTH(W), .P_CPOL(1), .P_CPHA(1), .P_MSB_FIRST(0)) dut1 (
    .clk_100  (clk_100),
    .a_rst_n  (a_rst_n),
    .SCK      (sck1),
    .CS       (cs1),
    .MISO     (miso1),
    .data_out (data_out1),
    .valid    (valid1),
    .ready    (ready1),
    .overrun  (overrun1),
    .ovr_clr  (ovr_clr1),
    .frame_err(frame_err1),
    .busy     (busy1)
  );

  int n_cmp = 0;
  int n_err = 0;
  logic [W-1:0] exp_q0[$];
  logic [W-1:0] exp_q1[$];
  logic [W-1:0] exp_w0, exp_w1;
  int fe_cnt0 = 0;
  int fe_cnt1 = 0;
  int fe_base;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitors, sampled on the falling clock edge
  always @(negedge clk_100) begin
    if (frame_err0) fe_cnt0++;
    if (frame_err1) fe_cnt1++;
    if (valid0 && ready0) begin
      check_val("d0_word_expected", 32'(exp_q0.size() > 0), 32'd1);
      if (exp_q0.size() > 0) begin
        exp_w0 = exp_q0.pop_front();
        $display("d0 rx data_out=0x%02h expected=0x%02h", data_out0, exp_w0);
        check_val("d0_data", 32'(data_out0), 32'(exp_w0));
      end
    end
    if (valid1 && ready1) begin
      check_val("d1_word_expected", 32'(exp_q1.size() > 0), 32'd1);
      if (exp_q1.size() > 0) begin
        exp_w1 = exp_q1.pop_front();
        $display("d1 rx data_out=0x%02h expected=0x%02h", data_out1, exp_w1);
        check_val("d1_data", 32'(data_out1), 32'(exp_w1));
      end
    end
  end

  // Advance n clocks; inputs change 2 ns after the rising edge
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_100);
      #2;
    end
  endtask

  task automatic drive_sck(input int d, input logic v);
    if (d == 0) sck0 = v; else sck1 = v;
  endtask

  task automatic drive_miso(input int d, input logic v);
    if (d == 0) miso0 = v; else miso1 = v;
  endtask

  task automatic drive_cs(input int d, input logic v);
    if (d == 0) cs0 = v; else cs1 = v;
  endtask

  // Drive n bits of w on the SPI pins of dut d in that dut's mode
  task automatic send_bits(input int d, input logic [W-1:0] w, input int n, input bit msb);
    logic cpol;
    logic cpha;
    logic b;
    cpol = (d != 0);
    cpha = (d != 0);
    for (int i = 0; i < n; i++) begin
      b = msb ? w[W-1-i] : w[i];
      if (!cpha) begin
        drive_miso(d, b);
        tick(H);
        drive_sck(d, ~cpol);
        tick(H);
        drive_sck(d, cpol);
      end else begin
        drive_sck(d, ~cpol);
        drive_miso(d, b);
        tick(H);
        drive_sck(d, cpol);
        tick(H);
      end
    end
  endtask

  task automatic frame_start(input int d);
    drive_cs(d, 1'b0);
    tick(6);
  endtask

  task automatic frame_end(input int d);
    tick(6);
    drive_cs(d, 1'b1);
    tick(8);
  endtask

  task automatic check_reset0(input string tag);
    check_val({tag, "_d0_data"},    32'(data_out0),  32'd0);
    check_val({tag, "_d0_valid"},   32'(valid0),     32'd0);
    check_val({tag, "_d0_overrun"}, 32'(overrun0),   32'd0);
    check_val({tag, "_d0_ferr"},    32'(frame_err0), 32'd0);
    check_val({tag, "_d0_busy"},    32'(busy0),      32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    a_rst_n  = 1'b0;
    sck0 = 1'b0; cs0 = 1'b1; miso0 = 1'b0; ready0 = 1'b0; ovr_clr0 = 1'b0;
    sck1 = 1'b1; cs1 = 1'b1; miso1 = 1'b0; ready1 = 1'b0; ovr_clr1 = 1'b0;
    tick(3);
    check_reset0("rst");
    check_val("rst_d1_valid", 32'(valid1), 32'd0);
    check_val("rst_d1_busy",  32'(busy1),  32'd0);
    a_rst_n = 1'b1;
    tick(4);

    // Mode 0 MSB-first single word with ready held high
    ready0  = 1'b1;
    fe_base = fe_cnt0;
    frame_start(0);
    check_val("t1_busy", 32'(busy0), 32'd1);
    exp_q0.push_back(8'hA5);
    send_bits(0, 8'hA5, 8, 1'b1);
    tick(6);
    check_val("t1_valid_dropped", 32'(valid0), 32'd0);
    check_val("t1_delivered", 32'(exp_q0.size()), 32'd0);
    frame_end(0);
    check_val("t1_no_ferr", 32'(fe_cnt0 - fe_base), 32'd0);
    check_val("t1_idle", 32'(busy0), 32'd0);

    // Mode 3 LSB-first: bits 1,0,1,1,0,0,0,0 assemble to 0x0D
    ready1  = 1'b1;
    fe_base = fe_cnt1;
    frame_start(1);
    exp_q1.push_back(8'h0D);
    send_bits(1, 8'h0D, 8, 1'b0);
    frame_end(1);
    check_val("t2_delivered", 32'(exp_q1.size()), 32'd0);
    check_val("t2_no_ferr", 32'(fe_cnt1 - fe_base), 32'd0);

    // Two words with the consumer stalled: second word is dropped
    ready0 = 1'b0;
    frame_start(0);
    exp_q0.push_back(8'h3C);
    send_bits(0, 8'h3C, 8, 1'b1);
    send_bits(0, 8'hC3, 8, 1'b1);
    frame_end(0);
    check_val("t3_valid_held", 32'(valid0), 32'd1);
    check_val("t3_data_held", 32'(data_out0), 32'h3C);
    check_val("t3_overrun_set", 32'(overrun0), 32'd1);
    ready0 = 1'b1;
    tick(2);
    check_val("t3_popped", 32'(valid0), 32'd0);
    check_val("t3_queue_empty", 32'(exp_q0.size()), 32'd0);
    check_val("t3_overrun_sticky", 32'(overrun0), 32'd1);
    ovr_clr0 = 1'b1;
    tick(1);
    ovr_clr0 = 1'b0;
    tick(1);
    check_val("t3_overrun_clr", 32'(overrun0), 32'd0);

    // Word completes in the same cycle the previous word is popped
    ready0 = 1'b0;
    frame_start(0);
    exp_q0.push_back(8'h5A);
    exp_q0.push_back(8'h96);
    send_bits(0, 8'h5A, 8, 1'b1);
    send_bits(0, 8'h96, 7, 1'b1);
    drive_miso(0, 1'b0);
    tick(H);
    drive_sck(0, 1'b1);   // last sampling edge of 0x96
    tick(2);
    ready0 = 1'b1;        // pop 0x5A in the cycle 0x96 is loaded
    tick(1);
    ready0 = 1'b0;
    check_val("t4_valid_kept", 32'(valid0), 32'd1);
    check_val("t4_new_data", 32'(data_out0), 32'h96);
    check_val("t4_no_overrun", 32'(overrun0), 32'd0);
    check_val("t4_one_left", 32'(exp_q0.size()), 32'd1);
    tick(H - 3);
    drive_sck(0, 1'b0);
    ready0 = 1'b1;
    tick(3);
    check_val("t4_drained", 32'(exp_q0.size()), 32'd0);
    frame_end(0);

    // Partial frame, then a clean frame
    fe_base = fe_cnt0;
    frame_start(0);
    send_bits(0, 8'hF0, 5, 1'b1);
    frame_end(0);
    check_val("t5_ferr_one_cycle", 32'(fe_cnt0 - fe_base), 32'd1);
    check_val("t5_no_valid", 32'(valid0), 32'd0);
    fe_base = fe_cnt0;
    frame_start(0);
    exp_q0.push_back(8'h81);
    send_bits(0, 8'h81, 8, 1'b1);
    frame_end(0);
    check_val("t5_recovered", 32'(exp_q0.size()), 32'd0);
    check_val("t5_no_ferr", 32'(fe_cnt0 - fe_base), 32'd0);

    // Reset in the middle of a frame with CS held low
    fe_base = fe_cnt0;
    frame_start(0);
    send_bits(0, 8'hFF, 4, 1'b1);
    a_rst_n = 1'b0;
    tick(2);
    check_reset0("t6_in_rst");
    a_rst_n = 1'b1;
    tick(4);
    check_reset0("t6_after_rst");
    send_bits(0, 8'h77, 8, 1'b1);
    tick(6);
    check_val("t6_no_start", 32'(busy0), 32'd0);
    check_val("t6_no_word", 32'(valid0), 32'd0);
    frame_end(0);
    check_val("t6_no_ferr", 32'(fe_cnt0 - fe_base), 32'd0);
    frame_start(0);
    exp_q0.push_back(8'h42);
    send_bits(0, 8'h42, 8, 1'b1);
    frame_end(0);
    check_val("t6_next_frame", 32'(exp_q0.size()), 32'd0);

    check_val("end_q1_empty", 32'(exp_q1.size()), 32'd0);
    check_val("end_d1_overrun", 32'(overrun1), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
